line_window_feeder_5row: RTL
============================

// Module: line_window_feeder_5row
// PURPOSE
//  Video-in front end for the 5x5 systolic 2D FIR. Takes a single raster pixel stream
//  with dv/hs/vs and produces five vertically aligned row taps (pixel0..pixel4) plus
//  delayed sync signals that feed the FIR's pixel0..4 / dv_i / hs_i / vs_i inputs.
//  Four single-port-per-side line memories, cascaded, hold the previous four lines.
// PARAMETERS
//  PIX_W      8     pixel width in bits
//  MAX_WIDTH  1024  maximum active pixels per line (line memory depth)
//  ADDR_W     10    column counter width; must satisfy 2**ADDR_W >= MAX_WIDTH
// PORTS
//  clk           in   1       system clock, all logic on rising edge
//  rst           in   1       asynchronous, active-low reset (0 = reset asserted)
//  dv_i          in   1       data valid, high during active pixels of a line
//  hs_i          in   1       horizontal sync, passed through delayed
//  vs_i          in   1       vertical sync, high at frame start
//  pixel_i       in   PIX_W   input pixel, sampled when dv_i=1
//  pixel0..4     out  PIX_W   row taps: pixel4 = current line, pixel0 = 4 lines earlier
//  dv_o,hs_o,vs_o out 1       dv_i/hs_i/vs_i delayed to align with pixel taps
//  line_ovf      out  1       sticky: a line exceeded MAX_WIDTH since last vs_i rise
// BEHAVIOUR
//  - Reset (rst=0): col_cnt=0, lines_valid=0, line_ovf=0, all pixel taps=0,
//    dv_o=hs_o=vs_o=0, sync delay line cleared. Memory contents not cleared; masked by
//    lines_valid. Reset mid-line discards the partial line; first full line after
//    release is treated as frame line 0.
//  - Latency: fixed 2 clk from pixel_i/dv_i/hs_i/vs_i to pixel0..4/dv_o/hs_o/vs_o.
//    Sync signals use a 2-stage register delay, independent of dv.
//  - Column counter: increments on each cycle with dv_i=1; cleared to 0 on the cycle
//    after dv_i falls (end of line). Saturates at MAX_WIDTH.
//  - Line cascade per accepted pixel at column c: mem0[c] <= pixel_i, memK[c] <=
//    previous content of mem(K-1)[c] (read-before-write, address pipelined to match
//    1-cycle read). Taps: pixel4=pixel_i, pixel3=mem0[c], pixel2=mem1[c],
//    pixel1=mem2[c], pixel0=mem3[c], all registered to meet the 2-cycle latency.
//  - lines_valid (0..4, saturating): cleared on vs_i rising edge; +1 on each dv_i
//    falling edge. Tap pixel(4-k) for k=1..4 outputs 0 when k > lines_valid
//    (zero-padding above the top of the frame). pixel4 is never masked.
//  - vs_i rising edge and dv_i falling edge in the same cycle: the line end is counted
//    first, then lines_valid cleared (result 0).
//  - Overflow: pixels with col_cnt >= MAX_WIDTH are not written to memory; their taps
//    pixel0..3 output 0, pixel4 passes through, line_ovf set to 1; cleared only by
//    vs_i rising edge or reset. Line still counted in lines_valid.
//  - When dv_i=0 taps hold their last value; consumers qualify with dv_o.
//  - No backpressure: one pixel accepted per dv_i cycle, continuous streaming required.
// TESTING
//  1. Reset: hold rst=0, toggle inputs -> all outputs 0, line_ovf=0; release, no dv -> outputs stay 0.
//  2. Frame of 6 lines x 8 px, pixel=16*line+col, vs pulse first -> line0: pixel0..3=0;
//     line5 col3: pixel4=0x53, pixel3=0x43, pixel2=0x33, pixel1=0x23, pixel0=0x13, 2 clk after input.
//  3. Latency: single dv/hs/vs pulses -> dv_o/hs_o/vs_o rise exactly 2 clk later, same width.
//  4. New frame: vs rise after 5 lines -> next line pixel0..3=0 again (stale memory masked).
//  5. Overflow (MAX_WIDTH=8): 10-px line -> cols 8,9 give pixel0..3=0, line_ovf=1 until next vs rise.
//  6. Async reset mid-line at col 4 -> outputs 0 immediately (no clk edge), next frame as test 2.

Source files
------------

// File: rtl/line_window_feeder_5row.sv
// Five-row vertical window feeder for the 5x5 2D FIR: four cascaded line memories
// turn one raster stream into five column-aligned row taps with matched sync delay.
module line_window_feeder_5row #(
  parameter int PIX_W     = 8,
  parameter int MAX_WIDTH = 1024,
  parameter int ADDR_W    = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dv_i,
  input  logic             hs_i,
  input  logic             vs_i,
  input  logic [PIX_W-1:0] pixel_i,
  output logic [PIX_W-1:0] pixel0,
  output logic [PIX_W-1:0] pixel1,
  output logic [PIX_W-1:0] pixel2,
  output logic [PIX_W-1:0] pixel3,
  output logic [PIX_W-1:0] pixel4,
  output logic             dv_o,
  output logic             hs_o,
  output logic             vs_o,
  output logic             line_ovf
);

  localparam int              DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] MAX_C = (ADDR_W + 1)'(MAX_WIDTH);

  // One extra bit so the counter can rest at MAX_WIDTH when it equals 2**ADDR_W.
  logic [ADDR_W:0]   col_cnt;
  logic              dv_d;
  logic              vs_d;
  logic [2:0]        lines_valid;
  logic [2:0]        sync1;

  logic [ADDR_W-1:0] addr_q;
  logic [PIX_W-1:0]  pix_q;
  logic              ovf_q;
  logic [2:0]        lv_q;

  logic [PIX_W-1:0]  mem0 [DEPTH];
  logic [PIX_W-1:0]  mem1 [DEPTH];
  logic [PIX_W-1:0]  mem2 [DEPTH];
  logic [PIX_W-1:0]  mem3 [DEPTH];
  logic [PIX_W-1:0]  rd0, rd1, rd2, rd3;

  logic col_ovf;
  logic vs_rise;
  logic dv_fall;

  assign col_ovf = (col_cnt >= MAX_C);
  assign vs_rise = vs_i & ~vs_d;
  assign dv_fall = dv_d & ~dv_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_cnt     <= '0;
      dv_d        <= 1'b0;
      vs_d        <= 1'b0;
      lines_valid <= '0;
      line_ovf    <= 1'b0;
      sync1       <= '0;
      dv_o        <= 1'b0;
      hs_o        <= 1'b0;
      vs_o        <= 1'b0;
      addr_q      <= '0;
      pix_q       <= '0;
      ovf_q       <= 1'b0;
      lv_q        <= '0;
      pixel0      <= '0;
      pixel1      <= '0;
      pixel2      <= '0;
      pixel3      <= '0;
      pixel4      <= '0;
    end else begin
      sync1              <= {dv_i, hs_i, vs_i};
      {dv_o, hs_o, vs_o} <= sync1;
      dv_d               <= dv_i;
      vs_d               <= vs_i;

      if (dv_i) begin
        if (!col_ovf) col_cnt <= col_cnt + 1'b1;
      end else begin
        col_cnt <= '0;
      end

      // A line ending in the same cycle as a frame start is absorbed by the clear.
      if (vs_rise)                             lines_valid <= '0;
      else if (dv_fall && lines_valid != 3'd4) lines_valid <= lines_valid + 3'd1;

      if (vs_rise)              line_ovf <= 1'b0;
      else if (dv_i && col_ovf) line_ovf <= 1'b1;

      if (dv_i) begin
        addr_q <= col_cnt[ADDR_W-1:0];
        pix_q  <= pixel_i;
        ovf_q  <= col_ovf;
        lv_q   <= lines_valid;
      end

      // Taps hold between lines; consumers qualify with dv_o.
      if (sync1[2]) begin
        pixel4 <= pix_q;
        pixel3 <= (ovf_q || lv_q < 3'd1) ? '0 : rd0;
        pixel2 <= (ovf_q || lv_q < 3'd2) ? '0 : rd1;
        pixel1 <= (ovf_q || lv_q < 3'd3) ? '0 : rd2;
        pixel0 <= (ovf_q || lv_q < 3'd4) ? '0 : rd3;
      end
    end
  end

  // Read at capture, write back one cycle later at the pipelined address.
  always_ff @(posedge clk) begin
    if (dv_i && !col_ovf) begin
      rd0 <= mem0[col_cnt[ADDR_W-1:0]];
      rd1 <= mem1[col_cnt[ADDR_W-1:0]];
      rd2 <= mem2[col_cnt[ADDR_W-1:0]];
      rd3 <= mem3[col_cnt[ADDR_W-1:0]];
    end
    if (sync1[2] && !ovf_q) begin
      mem0[addr_q] <= pix_q;
      mem1[addr_q] <= rd0;
      mem2[addr_q] <= rd1;
      mem3[addr_q] <= rd2;
    end
  end

endmodule
